branch_predictor: RTL

Parametrised branch prediction and redirect unit for the RV32 pipeline. It combines a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. The fetch stage gets a combinational taken/target prediction each cycle. The execute stage reports resolved branches and jumps. The block raises a PC redirect on misprediction, trains its tables on the next clock edge, and keeps branch and misprediction statistics.

---
 rtl/branch_predictor.sv | 112 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch prediction,
// same-cycle redirect on mispredict, next-edge training and branch statistics.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 10,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             ena,
  input  logic             flush,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             res_valid,
  input  logic             res_jump,
  input  logic [XLEN-1:0]  res_pc,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  input  logic             res_pred_taken,
  input  logic [XLEN-1:0]  res_pred_target,
  output logic             mispredict,
  output logic             pc_wr,
  output logic [XLEN-1:0]  pc_out,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [TAG_W-1:0] res_tag;
  logic [XLEN-1:0]  res_tgt_m;
  logic             active;
  logic             res_hit;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_next;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign res_idx   = res_pc[IDX_W+1:2];
  assign res_tag   = res_pc[IDX_W+1+TAG_W:IDX_W+2];

  // Lookup reads registered state only, so training is never bypassed to fetch.
  assign pred_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken  = pred_hit && cnt_q[fetch_idx][1];
  assign pred_target = pred_taken ? tgt_q[fetch_idx] : fetch_pc + PC_STEP;

  assign res_tgt_m  = res_target & ~XLEN'(1);
  assign active     = res_valid && ena && nreset;
  assign mispredict = active && ((res_taken != res_pred_taken) ||
                                 (res_taken && (res_pred_target != res_tgt_m)));
  assign pc_wr      = mispredict;
  assign pc_out     = (active && res_taken) ? res_tgt_m : res_pc + PC_STEP;

  assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
  assign cnt_cur = cnt_q[res_idx];

  always_comb begin
    cnt_next = cnt_cur;
    if (res_jump) begin
      cnt_next = 2'b11;
    end else if (res_taken) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'd1;
    end
  end

  // Flush wins over training in the same cycle, but the statistics still count it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q   <= '0;
      br_count  <= '0;
      mis_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else if (ena) begin
      if (res_valid) begin
        br_count <= br_count + CNT_W'(1);
        if (mispredict) mis_count <= mis_count + CNT_W'(1);
      end
      if (flush) begin
        valid_q <= '0;
      end else if (res_valid) begin
        if (res_hit) begin
          cnt_q[res_idx] <= cnt_next;
          if (res_taken) tgt_q[res_idx] <= res_tgt_m;
        end else if (res_taken) begin
          valid_q[res_idx] <= 1'b1;
          tag_q[res_idx]   <= res_tag;
          tgt_q[res_idx]   <= res_tgt_m;
          cnt_q[res_idx]   <= res_jump ? 2'b11 : 2'b10;
        end
      end
    end
  end

endmodule
